// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the two-instruction fetch buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: word/slot widths, the stored entry record {pc, bundle}, and a
// wrapping PC adder used for the head-bundle address outputs.

package fetch_buffer_pkg;

   localparam int WORD_W      = 16;               // PC and instruction word width
   localparam int SLOT_W      = 16;               // one instruction slot
   localparam int SLOTS       = 2;                // instructions per bundle
   localparam int BUNDLE_W    = SLOT_W * SLOTS;   // 32-bit fetch bundle
   localparam int INSTR_BYTES = 2;                // byte stride between slots

   // One buffered bundle: address of slot 1 plus both instruction half-words.
   typedef struct packed {
      logic [WORD_W-1:0]   pc;
      logic [BUNDLE_W-1:0] bundle;
   } entry_t;

   // PC offset arithmetic wraps at 2^16 so addresses near the top of memory
   // roll over to low addresses instead of growing a carry bit.
   function automatic logic [WORD_W-1:0] pc_add(input logic [WORD_W-1:0] pc,
                                                input logic [WORD_W-1:0] offset);
      return pc + offset;
   endfunction

endpackage

// File: rtl/fetch_buffer_ctrl.sv
// Pointer/count bookkeeping for the fetch buffer circular queue.
// Latency: push/pop take effect on the next rising edge; flags are registered-state only.
// Backpressure: fetch_ready = !full; a full queue refuses writes even when popping.
// Ports:
//   clock, reset          - core clock, asynchronous active-low reset
//   fetch_valid, enable   - producer offers a bundle / consumer takes the head
//   flush                 - discard everything; wins over push and pop
//   push, pop             - qualified events for the storage array
//   wr_ptr, rd_ptr, count - queue state; empty/full/fetch_ready derived from count

module fetch_buffer_ctrl
   import fetch_buffer_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             fetch_valid,
   input  logic             enable,
   input  logic             flush,
   output logic             push,
   output logic             pop,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             fetch_ready
);

   // Flags depend only on the registered count, so fetch_ready never
   // combinationally follows enable.
   assign empty       = (count == '0);
   assign full        = (count == CNT_W'(DEPTH));
   assign fetch_ready = !full;

   assign push = fetch_valid && !full && !flush;
   assign pop  = enable && !empty && !flush;

   // DEPTH is a power of two, so natural PTR_W-bit overflow is the modulo wrap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: queues two-instruction bundles between I-mem and the IF/ID stage.
// Latency: one cycle from accepted push to head visibility (no bypass).
// Backpressure: fetch_ready drops when DEPTH bundles are held; enable pops the head.
// Ports:
//   clock, reset                      - core clock, asynchronous active-low reset
//   fetch_valid/fetch_pc/fetch_bundle - incoming bundle, fetch_ready accepts it
//   enable, flush                     - consume head / discard all (redirect)
//   instr1/2, pc1/2, pc_plus2_1/2     - head bundle slots and their addresses
//   valid1/2, occupancy, empty, full  - head validity and fill status
// DEPTH must be a power of two and at least 2.

module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                fetch_valid,
   input  logic [WORD_W-1:0]   fetch_pc,
   input  logic [BUNDLE_W-1:0] fetch_bundle,
   output logic                fetch_ready,
   input  logic                enable,
   input  logic                flush,
   output logic [SLOT_W-1:0]   instr1,
   output logic [SLOT_W-1:0]   instr2,
   output logic [WORD_W-1:0]   pc1,
   output logic [WORD_W-1:0]   pc2,
   output logic [WORD_W-1:0]   pc_plus2_1,
   output logic [WORD_W-1:0]   pc_plus2_2,
   output logic                valid1,
   output logic                valid2,
   output logic [CNT_W-1:0]    occupancy,
   output logic                empty,
   output logic                full
);

   logic             push;
   logic             pop;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   entry_t mem [DEPTH];
   entry_t head;

   fetch_buffer_ctrl #(
      .DEPTH(DEPTH)
   ) u_ctrl (
      .clock       (clock),
      .reset       (reset),
      .fetch_valid (fetch_valid),
      .enable      (enable),
      .flush       (flush),
      .push        (push),
      .pop         (pop),
      .wr_ptr      (wr_ptr),
      .rd_ptr      (rd_ptr),
      .count       (occupancy),
      .empty       (empty),
      .full        (full),
      .fetch_ready (fetch_ready)
   );

   // Entries are cleared on reset so the head outputs are never X, even
   // while invalid. Flush only moves pointers; stale data stays unreadable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= '{pc: fetch_pc, bundle: fetch_bundle};
      end
   end

   assign head = mem[rd_ptr];

   // Slot 1 (low half-word) is the older instruction of the bundle.
   assign instr1 = head.bundle[SLOT_W-1:0];
   assign instr2 = head.bundle[BUNDLE_W-1:SLOT_W];

   assign pc1        = head.pc;
   assign pc2        = pc_add(head.pc, WORD_W'(INSTR_BYTES));
   assign pc_plus2_1 = pc2;
   assign pc_plus2_2 = pc_add(head.pc, WORD_W'(2 * INSTR_BYTES));

   // A flushing cycle must not hand a bundle to decode.
   assign valid1 = !empty && !flush;
   assign valid2 = !empty && !flush;

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of two-instruction bundle entries; power of two, at least 2.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 fetch_valid  input  1  instruction memory presents a bundle this cycle.
REQ-005 fetch_pc  input  16  address of the bundle's first instruction.
REQ-006 fetch_bundle  input  32  bits [15:0] are slot-1 instruction; bits [31:16] are slot-2 instruction.
REQ-007 fetch_ready  output  1  buffer accepts a bundle this cycle.
REQ-008 enable  input  1  downstream IF/ID stage consumes the head bundle this cycle (pipeline enable).
REQ-009 flush  input  1  branch redirect; discard all buffered bundles.
REQ-010 instr1, instr2  output  16 each  head-bundle slot-1 and slot-2 instructions.
REQ-011 pc1, pc2  output  16 each  head PC, and head PC + 2.
REQ-012 pc_plus2_1, pc_plus2_2  output  16 each  head PC + 2, and head PC + 4.
REQ-013 valid1, valid2  output  1 each  the head bundle is valid for slot 1 and slot 2.
REQ-014 occupancy  output  log2(DEPTH)+1  number of stored bundles.
REQ-015 empty, full  output  1 each  occupancy == 0, and occupancy == DEPTH.

Function
REQ-016 Storage is a circular queue of DEPTH entries, each holding {pc[15:0], bundle[31:0]}, with a write pointer, a read pointer and a count.
REQ-017 fetch_ready = !full, derived from registered state only; there is no combinational path from enable.
REQ-018 Push occurs when fetch_valid && fetch_ready && !flush: write the entry at the write pointer, then advance the write pointer modulo DEPTH.
REQ-019 Pop occurs when enable && !empty && !flush: advance the read pointer modulo DEPTH.
REQ-020 Push and pop in the same cycle leave count unchanged; push alone adds 1; pop alone subtracts 1.
REQ-021 Head outputs are driven combinationally from the entry at the read pointer; no data bypass exists, so latency from push to head visibility is 1 cycle.
REQ-022 valid1 = valid2 = !empty && !flush; when invalid, instr and pc outputs are don't-care but SHALL NOT be X after reset (all entries are reset to 0).
REQ-023 pc2, pc_plus2_1 and pc_plus2_2 use modulo-2^16 addition; 16'hFFFE yields pc2 = 16'h0000 and pc_plus2_2 = 16'h0002.
REQ-024 Flush has priority over push and pop: on the next edge, count = 0 and both pointers = 0; the bundle presented in the flush cycle is dropped.
REQ-025 When full, a fetch_valid bundle is not written even if a pop occurs in the same cycle; the source holds it until fetch_ready.
REQ-026 When empty, enable has no effect on state.
REQ-027 Slot order is fixed: slot 1 (lower half-word) is always older than slot 2.

Reset
REQ-028 While reset is low: count = 0, both pointers = 0, all entries = 0; hence empty = 1, full = 0, fetch_ready = 1, valid1 = valid2 = 0, occupancy = 0.
REQ-029 Reset assertion mid-operation discards contents immediately (asynchronous); the first push is accepted on the first rising edge after release.

Structure
REQ-030 Shared package holds the bundle entry record type {pc, bundle}, the 16-bit word width and the slot-width constants.
REQ-031 A single sub-module, fetch_buffer_ctrl, owns the pointers, count, full/empty and the push/pop/flush decisions; the top level owns entry storage and the PC adders.

Verification
REQ-032 Reset, then push pc=0x0010, bundle=0x1234_5678 -> next cycle: instr1=0x5678, instr2=0x1234, pc1=0x0010, pc2=0x0012, pc_plus2_2=0x0014, valid1=valid2=1.
REQ-033 Push 4 bundles with enable=0 (DEPTH=4) -> full=1, fetch_ready=0, occupancy=4; a 5th fetch_valid is not stored; pop order matches push order.
REQ-034 Simultaneous push and pop at occupancy 2 for 10 cycles -> occupancy stays 2; pointers wrap past 3 to 0 with data intact.
REQ-035 Occupancy 3 with flush=1 together with fetch_valid=1 -> valid1=valid2=0 in that cycle; next cycle occupancy=0, empty=1, and the flush-cycle bundle is absent.
REQ-036 Push pc=0xFFFE -> pc2=0x0000, pc_plus2_1=0x0000, pc_plus2_2=0x0002.
REQ-037 Assert reset low mid-cycle at occupancy 2 -> empty=1 and valid1=0 immediately, without waiting for a clock edge.
